// File: rtl/temporizador_pkg.sv
// Shared definitions for the programmable BCD MM:SS timer.
// Holds the state encoding, the BCD limits and the load-validity helpers.
package temporizador_pkg;

    localparam logic [1:0] ENC_IDLE    = 2'd0;
    localparam logic [1:0] ENC_RUN     = 2'd1;
    localparam logic [1:0] ENC_PAUSE   = 2'd2;
    localparam logic [1:0] ENC_EXPIRED = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ENC_IDLE,
        S_RUN     = ENC_RUN,
        S_PAUSE   = ENC_PAUSE,
        S_EXPIRED = ENC_EXPIRED
    } state_t;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [2:0] SEC_TENS_MAX = 3'd5;

    function automatic logic bcd_digit_ok(input logic [3:0] d);
        return d <= DIGIT_MAX;
    endfunction

    // Seconds field is {tens[2:0], units[3:0]}; tens may not go past 5.
    function automatic logic bcd_sec_ok(input logic [6:0] s);
        return (s[6:4] <= SEC_TENS_MAX) && bcd_digit_ok(s[3:0]);
    endfunction

endpackage

// File: rtl/contador_bcd_mod.sv
// One-digit modulo-MOD counter used as a link in the BCD time chain.
// carry marks the enabled cycle on which the digit wraps to zero.
module contador_bcd_mod
    import temporizador_pkg::*;
#(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign carry = en & (q == LAST);

    always_ff @(posedge clk) begin
        if (!clr) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (en) begin
            q <= (q == LAST) ? '0 : q + 1'b1;
        end
    end

endmodule

// File: rtl/temporizador_param.sv
// Programmable security timer: counts BCD MM:SS up to a loaded target and
// raises hab on expiry, with pause, cancel, auto-reload and a tick prescaler.
module temporizador_param
    import temporizador_pkg::*;
#(
    parameter int TICK_DIV   = 1,
    parameter int MIN_DIGITS = 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    cancel,
    input  logic                    mode,
    input  logic [4*MIN_DIGITS-1:0] load_min,
    input  logic [6:0]              load_sec,
    output logic [3:0]              seg_sec_u,
    output logic [2:0]              seg_sec_t,
    output logic [4*MIN_DIGITS-1:0] seg_min,
    output logic                    running,
    output logic                    hab,
    output logic                    done_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t                  state, state_nxt;
    logic [PW-1:0]           presc, presc_nxt;
    logic [4*MIN_DIGITS-1:0] target_min;
    logic [6:0]              target_sec;
    logic                    latch_target, clear_target, clear_digits;
    logic                    hab_nxt, done_nxt;
    logic                    counting, tick, at_target;
    logic                    load_ok, load_zero, target_zero;
    logic                    sec_u_carry, sec_t_carry;
    logic [MIN_DIGITS:0]     min_carry;
    logic                    chain_unused;
    logic [3:0]              inc_sec_u;
    logic [2:0]              inc_sec_t;
    logic [4*MIN_DIGITS-1:0] inc_min;
    logic                    c_inc;
    logic [3:0]              d;

    // A PAUSE cycle with pause released counts exactly like a RUN cycle.
    assign counting    = ((state == S_RUN) || (state == S_PAUSE)) && !cancel && !pause;
    assign tick        = counting && (presc == PRESC_LAST);
    assign load_zero   = (load_min == '0) && (load_sec == '0);
    assign target_zero = (target_min == '0) && (target_sec == '0);

    always_comb begin
        load_ok = bcd_sec_ok(load_sec);
        for (int i = 0; i < MIN_DIGITS; i++) begin
            load_ok = load_ok && bcd_digit_ok(load_min[4*i +: 4]);
        end
    end

    // Value the display would show after one more tick; compared with the
    // target so expiry lands on the same edge that reaches it.
    always_comb begin
        d         = '0;
        c_inc     = (seg_sec_u == DIGIT_MAX);
        inc_sec_u = c_inc ? 4'd0 : seg_sec_u + 4'd1;
        inc_sec_t = seg_sec_t;
        if (c_inc) begin
            inc_sec_t = (seg_sec_t == SEC_TENS_MAX) ? 3'd0 : seg_sec_t + 3'd1;
        end
        c_inc   = c_inc && (seg_sec_t == SEC_TENS_MAX);
        inc_min = seg_min;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            d = seg_min[4*i +: 4];
            if (c_inc) begin
                inc_min[4*i +: 4] = (d == DIGIT_MAX) ? 4'd0 : d + 4'd1;
            end
            c_inc = c_inc && (d == DIGIT_MAX);
        end
    end

    assign at_target = ({inc_min, inc_sec_t, inc_sec_u} == {target_min, target_sec});

    always_comb begin
        state_nxt    = state;
        presc_nxt    = presc;
        latch_target = 1'b0;
        clear_target = 1'b0;
        clear_digits = 1'b0;
        hab_nxt      = hab;
        done_nxt     = 1'b0;

        if (cancel) begin
            state_nxt    = S_IDLE;
            presc_nxt    = '0;
            clear_target = 1'b1;
            clear_digits = 1'b1;
            hab_nxt      = 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_EXPIRED: begin
                    if (start && load_ok) begin
                        latch_target = 1'b1;
                        clear_digits = 1'b1;
                        presc_nxt    = '0;
                        if (load_zero) begin
                            state_nxt = S_EXPIRED;
                            hab_nxt   = 1'b1;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_RUN;
                            hab_nxt   = 1'b0;
                        end
                    end else if ((state == S_EXPIRED) && mode) begin
                        // A zero target reloads into an immediate re-expiry.
                        if (target_zero) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt    = S_RUN;
                            clear_digits = 1'b1;
                            presc_nxt    = '0;
                            hab_nxt      = 1'b0;
                        end
                    end
                end
                S_RUN, S_PAUSE: begin
                    if (pause) begin
                        state_nxt = S_PAUSE;
                    end else begin
                        state_nxt = S_RUN;
                        if (tick) begin
                            presc_nxt = '0;
                            if (at_target) begin
                                state_nxt = S_EXPIRED;
                                hab_nxt   = 1'b1;
                                done_nxt  = 1'b1;
                            end
                        end else begin
                            presc_nxt = presc + 1'b1;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state      <= S_IDLE;
            presc      <= '0;
            target_min <= '0;
            target_sec <= '0;
            hab        <= 1'b0;
            done_pulse <= 1'b0;
            running    <= 1'b0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            if (clear_target) begin
                target_min <= '0;
                target_sec <= '0;
            end else if (latch_target) begin
                target_min <= load_min;
                target_sec <= load_sec;
            end
            hab        <= hab_nxt;
            done_pulse <= done_nxt;
            running    <= (state_nxt == S_RUN) || (state_nxt == S_PAUSE);
        end
    end

    contador_bcd_mod #(.MOD(10), .W(4)) u_sec_u (
        .clk   (clk),
        .clr   (clr),
        .clear (clear_digits),
        .en    (tick),
        .q     (seg_sec_u),
        .carry (sec_u_carry)
    );

    contador_bcd_mod #(.MOD(6), .W(3)) u_sec_t (
        .clk   (clk),
        .clr   (clr),
        .clear (clear_digits),
        .en    (sec_u_carry),
        .q     (seg_sec_t),
        .carry (sec_t_carry)
    );

    assign min_carry[0] = sec_t_carry;

    for (genvar i = 0; i < MIN_DIGITS; i++) begin : g_min
        contador_bcd_mod #(.MOD(10), .W(4)) u_min (
            .clk   (clk),
            .clr   (clr),
            .clear (clear_digits),
            .en    (min_carry[i]),
            .q     (seg_min[4*i +: 4]),
            .carry (min_carry[i+1])
        );
    end

    // The top minute carry can never fire because the count stops at target.
    assign chain_unused = min_carry[MIN_DIGITS];

endmodule

// File: doc/temporizador_param.md
Name: temporizador_param

Overview:
Programmable, parametrised successor of the fixed 3-minute security timer. It counts up in BCD MM:SS from 00:00 to a run-time loaded duration. It adds start, pause, cancel, one-shot/auto-reload mode and a clock prescaler. The block drives the display digits and the expiry flag `hab` consumed by the alarm controller.

Parameters:
TICK_DIV, 1, clk cycles per counted second; 1 means clk is already the 1 Hz tick.
MIN_DIGITS, 1, number of BCD minute digits (1 or 2); maximum duration is 9:59 or 99:59.

Ports:
clk  in  1  system clock; all logic on its rising edge
clr  in  1  reset, synchronous, active-low (clr=0 resets on next clk edge)
start  in  1  single-cycle strobe; latches load_min/load_sec and starts counting
pause  in  1  level; while high in RUN, counting freezes
cancel  in  1  single-cycle strobe; abort to IDLE
mode  in  1  0 = one-shot, 1 = auto-reload
load_min  in  4*MIN_DIGITS  BCD minutes of the target duration
load_sec  in  7  BCD seconds; [6:4] tens, [3:0] units
seg_sec_u  out  4  BCD seconds units
seg_sec_t  out  3  BCD seconds tens
seg_min  out  4*MIN_DIGITS  BCD minutes
running  out  1  high in RUN and PAUSE
hab  out  1  expiry level
done_pulse  out  1  one-cycle pulse on each expiry

Behaviour:
- Reset (clr=0): state IDLE; all digits 0; prescaler 0; target 0; running=0, hab=0, done_pulse=0. Reset has absolute priority, including mid-run.
- Event priority each cycle: clr > cancel > start > pause > tick.
- States: IDLE, RUN, PAUSE, EXPIRED. Encoding lives in the package. All outputs are registered.
- IDLE:
  - On start, validate the load. A digit >9 or seconds tens >5 is invalid: ignore start and stay IDLE.
  - Valid, non-zero load: latch it into target, clear the digits and prescaler, go to RUN.
  - Valid load of 00:00: go directly to EXPIRED, with hab=1 and done_pulse=1 after the same edge.
- RUN:
  - The prescaler counts 0..TICK_DIV-1. The tick fires on the cycle where it equals TICK_DIV-1; the prescaler then wraps to 0.
  - On a tick, increment the BCD chain: sec_u mod 10, carry into sec_t mod 6, carry into minute digits mod 10 each.
  - With TICK_DIV=1, the display shows 00:01 after the first RUN edge.
  - On the edge where the incremented value equals target: enter EXPIRED, assert hab=1 and done_pulse=1 for one cycle. The display holds target.
  - pause=1: go to PAUSE with no increment that cycle.
  - start while in RUN: ignored.
  - cancel: go to IDLE and clear everything.
- PAUSE:
  - Digits and prescaler hold.
  - pause=0: return to RUN; counting resumes from the held prescaler value.
  - cancel: go to IDLE.
- EXPIRED:
  - mode=0: hold hab=1 and the display. cancel goes to IDLE. A valid start reloads and restarts, as from IDLE.
  - mode=1: on the next edge, clear digits and prescaler, deassert hab, return to RUN. The expiry period is target-seconds × TICK_DIV + 1 cycles.
- Width rules:
  - The counter never exceeds target, so no wrap past the maximum occurs.
  - The target is sampled only at start or reload; load inputs changing during RUN have no effect.
  - mode is sampled continuously and takes effect in EXPIRED.

Decomposition:
- Package temporizador_pkg:
  - state encoding localparams (IDLE, RUN, PAUSE, EXPIRED);
  - BCD constants (DIGIT_MAX=9, SEC_TENS_MAX=5);
  - BCD validity check function.
- Sub-module contador_bcd_mod: a one-digit counter with parameter MOD, ports clk, clr (sync active-low), clear, en, q, carry. carry = en & (q==MOD-1).
- Instantiate contador_bcd_mod once per digit: MOD=10, MOD=6, then MOD=10 for each minute digit.
- The top level holds the FSM, prescaler, target register and comparator.

Test Plan:
1. TICK_DIV=1, MIN_DIGITS=1, mode=0, load 3:00, start at edge 0 -> 0:59→1:00 carry after edge 60. At edge 180: display 3:00, done_pulse=1 for one cycle, hab=1, held for 20 further cycles.
2. TICK_DIV=4, load 0:02, start; after 3 RUN cycles hold pause=1 for 10 cycles -> digits and prescaler frozen during pause. done_pulse at edge 18 (8 counting cycles + 10 paused), display 0:02.
3. mode=1, TICK_DIV=1, load 0:05 -> done_pulse at edges 5, 11, 17. hab high only on those cycles; display returns to 0:00 the cycle after each.
4. load 0:00 start -> hab=1 and done_pulse=1 after the next edge. load_sec tens=6 with start -> state IDLE, running=0, all outputs unchanged.
5. clr=0 for one cycle at display 1:37 in RUN -> next edge: all digits 0, running=0, hab=0. With clr=1 and no start, the block stays IDLE.
6. cancel and start asserted together in RUN; also in EXPIRED with mode=0 -> IDLE with digits 0 (cancel wins). A later start alone restarts with the new load.
